// File: rtl/jtframe_msg_writer_if.sv
// jtframe_msg_writer_if: command handshake and VRAM write port of the message writer
interface jtframe_msg_writer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        cmd_pal;
  logic        busy;
  logic [4:0]  cursor_row;
  logic [4:0]  cursor_col;
  logic [9:0]  vram_addr;
  logic [7:0]  vram_din;
  logic        vram_we;
  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_pal,
    input  cmd_ready, busy, cursor_row, cursor_col, vram_addr, vram_din, vram_we
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_pal,
    output cmd_ready, busy, cursor_row, cursor_col, vram_addr, vram_din, vram_we
  );
endinterface

// File: rtl/jtframe_msg_writer.sv
// jtframe_msg_writer: command-driven text engine for the 32x32 message VRAM; define JTFRAME_MSG_WRITER_DEC_EN to turn opcode 0 into DEC8
module jtframe_msg_writer #(
  parameter logic [7:0] BLANK       = 8'h20,
  parameter logic [9:0] ADDR_OFFSET = 10'd0
)(
  input logic clk,
  input logic rst,
  jtframe_msg_writer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WRITE, FILL, DONE
`ifdef JTFRAME_MSG_WRITER_DEC_EN
    , CONV
`endif
  } state_t;
  typedef enum logic [2:0] {OP_NOP, OP_CLEAR, OP_PUTC, OP_HEX8, OP_HEX16, OP_LOCATE, OP_NEWLINE, OP_CLEOL} op_t;
  state_t      state, state_nx;
  op_t         op, op_nx;
  logic        busy, busy_nx, pal, pal_nx, we, we_nx;
  logic [9:0]  pos, pos_nx, fpos, fpos_nx, addr, addr_nx;
  logic [15:0] shf, shf_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [7:0]  din, din_nx;
  logic [6:0]  ch;
`ifdef JTFRAME_MSG_WRITER_DEC_EN
  logic [7:0]  rem, rem_nx;
  logic [3:0]  hun, hun_nx, ten, ten_nx;
`endif
  function automatic logic [6:0] hex(input logic [3:0] n);
    return n < 4'd10 ? 7'h30 + {3'd0, n} : 7'h37 + {3'd0, n};
  endfunction
  assign ch             = op == OP_PUTC ? shf[15:9] : hex(shf[15:12]);
  assign bus.cmd_ready  = !busy;
  assign bus.busy       = busy;
  assign bus.cursor_row = pos[9:5];
  assign bus.cursor_col = pos[4:0];
  assign bus.vram_addr  = addr;
  assign bus.vram_din   = din;
  assign bus.vram_we    = we;
  always_comb begin
    state_nx = state;
    busy_nx  = busy;
    pos_nx   = pos;
    op_nx    = op;
    pal_nx   = pal;
    shf_nx   = shf;
    cnt_nx   = cnt;
    fpos_nx  = fpos;
    addr_nx  = addr;
    din_nx   = din;
    we_nx    = 1'b0;
`ifdef JTFRAME_MSG_WRITER_DEC_EN
    rem_nx   = rem;
    hun_nx   = hun;
    ten_nx   = ten;
`endif
    case (state)
      IDLE: if (bus.cmd_valid) begin
        busy_nx = 1'b1;
        op_nx   = op_t'(bus.cmd_op);
        pal_nx  = bus.cmd_pal;
        fpos_nx = bus.cmd_op == OP_CLEAR ? 10'd0 : pos;
        cnt_nx  = bus.cmd_op == OP_HEX16 ? 3'd4 : bus.cmd_op == OP_HEX8 ? 3'd2 : 3'd1;
        shf_nx  = bus.cmd_op == OP_HEX8 ? {bus.cmd_data[7:0], 8'd0} :
                  bus.cmd_op == OP_PUTC ? {bus.cmd_data[6:0], 9'd0} : bus.cmd_data;
        case (op_t'(bus.cmd_op))
          OP_CLEAR, OP_CLEOL:         state_nx = FILL;
          OP_PUTC, OP_HEX8, OP_HEX16: state_nx = WRITE;
          OP_LOCATE: begin
            pos_nx   = {bus.cmd_data[12:8], bus.cmd_data[4:0]};
            state_nx = DONE;
          end
          OP_NEWLINE: begin
            pos_nx   = {pos[9:5] + 5'd1, 5'd0};
            state_nx = DONE;
          end
          default: begin
`ifdef JTFRAME_MSG_WRITER_DEC_EN
            rem_nx   = bus.cmd_data[7:0];
            hun_nx   = 4'd0;
            ten_nx   = 4'd0;
            state_nx = CONV;
`else
            state_nx = DONE;
`endif
          end
        endcase
      end
`ifdef JTFRAME_MSG_WRITER_DEC_EN
      CONV: begin
        if (rem >= 8'd100) begin
          rem_nx = rem - 8'd100;
          hun_nx = hun + 4'd1;
        end else if (rem >= 8'd10) begin
          rem_nx = rem - 8'd10;
          ten_nx = ten + 4'd1;
        end else begin
          shf_nx   = {hun, ten, rem[3:0], 4'd0};
          cnt_nx   = 3'd3;
          state_nx = WRITE;
        end
      end
`endif
      WRITE: begin
        we_nx   = 1'b1;
        addr_nx = pos + ADDR_OFFSET;
        din_nx  = {pal, ch};
        pos_nx  = pos + 10'd1;
        shf_nx  = shf << 4;
        cnt_nx  = cnt - 3'd1;
        if (cnt == 3'd1) state_nx = DONE;
      end
      FILL: begin
        we_nx   = 1'b1;
        addr_nx = fpos + ADDR_OFFSET;
        din_nx  = {1'b0, BLANK[6:0]};
        fpos_nx = fpos + 10'd1;
        // CLEOL stops at the row end, CLEAR at the last byte of the page
        if (fpos[4:0] == 5'd31 && (op == OP_CLEOL || fpos[9:5] == 5'd31)) begin
          state_nx = DONE;
          pos_nx   = op == OP_CLEAR ? 10'd0 : pos;
        end
      end
      default: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      pos   <= 10'd0;
      op    <= OP_NOP;
      pal   <= 1'b0;
      shf   <= 16'd0;
      cnt   <= 3'd0;
      fpos  <= 10'd0;
      addr  <= 10'd0;
      din   <= 8'd0;
      we    <= 1'b0;
`ifdef JTFRAME_MSG_WRITER_DEC_EN
      rem   <= 8'd0;
      hun   <= 4'd0;
      ten   <= 4'd0;
`endif
    end else begin
      state <= state_nx;
      busy  <= busy_nx;
      pos   <= pos_nx;
      op    <= op_nx;
      pal   <= pal_nx;
      shf   <= shf_nx;
      cnt   <= cnt_nx;
      fpos  <= fpos_nx;
      addr  <= addr_nx;
      din   <= din_nx;
      we    <= we_nx;
`ifdef JTFRAME_MSG_WRITER_DEC_EN
      rem   <= rem_nx;
      hun   <= hun_nx;
      ten   <= ten_nx;
`endif
    end
endmodule

// File: tb/tb_jtframe_msg_writer.sv
// tb_jtframe_msg_writer: directed and random commands checked against a cursor/VRAM-write reference model
module tb_jtframe_msg_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0, n_fail = 0, cyc = 0, mpos = 0, t_acc = 0, t_prev = 0;
  logic [2:0] cur_op = 3'd0;
  logic [9:0] exp_a[$], wa[$];
  logic [7:0] exp_d[$], wd[$];
  int wc[$];
  jtframe_msg_writer_if bus();
  jtframe_msg_writer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (bus.vram_we) begin
      wa.push_back(bus.vram_addr);
      wd.push_back(bus.vram_din);
      wc.push_back(cyc);
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask
  function automatic logic [31:0] got_a(input int k);
    return k < wa.size() ? 32'(wa[k]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] got_d(input int k);
    return k < wd.size() ? 32'(wd[k]) : 32'hFFFF_FFFF;
  endfunction
  task automatic push(input int a, input logic [7:0] v);
    exp_a.push_back(10'(a % 1024));
    exp_d.push_back(v);
  endtask
  // Reference: what a command should write, and where the cursor ends up
  task automatic model_cmd(input logic [2:0] op, input logic [15:0] d, input logic p);
    int n, v;
    int dg[3];
    logic [3:0] nib;
    logic [7:0] ch;
    exp_a.delete();
    exp_d.delete();
    case (op)
      3'd0: begin
`ifdef JTFRAME_MSG_WRITER_DEC_EN
        v = int'(d[7:0]);
        dg = '{v / 100, (v / 10) % 10, v % 10};
        for (int i = 0; i < 3; i++) begin
          ch = 8'(48 + dg[i]);
          push(mpos, {p, ch[6:0]});
          mpos = (mpos + 1) % 1024;
        end
`endif
      end
      3'd1: begin
        for (int a = 0; a < 1024; a++) push(a, 8'h20);
        mpos = 0;
      end
      3'd2: begin
        push(mpos, {p, d[6:0]});
        mpos = (mpos + 1) % 1024;
      end
      3'd3, 3'd4: begin
        n = op == 3'd3 ? 2 : 4;
        for (int i = 0; i < n; i++) begin
          nib = 4'((d >> (4 * (n - 1 - i))) & 16'hF);
          ch = nib < 4'd10 ? 8'(48 + int'(nib)) : 8'(65 + int'(nib) - 10);
          push(mpos, {p, ch[6:0]});
          mpos = (mpos + 1) % 1024;
        end
      end
      3'd5: mpos = int'(d[12:8]) * 32 + int'(d[4:0]);
      3'd6: mpos = ((mpos / 32 + 1) % 32) * 32;
      default: for (int c = mpos % 32; c < 32; c++) push((mpos / 32) * 32 + c, 8'h20);
    endcase
  endtask
  task automatic start(input logic [2:0] op, input logic [15:0] d, input logic p);
    int n = 0;
    model_cmd(op, d, p);
    cur_op = op;
    @(negedge clk);
    wa.delete();
    wd.delete();
    wc.delete();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.cmd_pal   = p;
    while (!bus.cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("ready before accept", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    t_acc = cyc;
    bus.cmd_valid = 1'b0;
  endtask
  task automatic finish(input string tag);
    int n = 0, t_rdy;
    bit dec = 1'b0;
`ifdef JTFRAME_MSG_WRITER_DEC_EN
    dec = cur_op == 3'd0;
`endif
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 3000);
    #1;
    t_rdy = cyc;
    chk({tag, " ready back"}, bus.cmd_ready, 1);
    chk({tag, " write count"}, wa.size(), exp_a.size());
    for (int i = 0; i < wa.size() && i < exp_a.size(); i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), wa[i], exp_a[i]);
      chk($sformatf("%s din[%0d]", tag, i), wd[i], exp_d[i]);
      chk($sformatf("%s wcyc[%0d]", tag, i), wc[i], wc[0] + i);
    end
    if (!dec) begin
      if (wc.size() > 0) chk({tag, " first write"}, wc[0], t_acc + 1);
      chk({tag, " ready time"}, t_rdy, t_acc + exp_a.size() + 1);
    end else if (wc.size() > 0) begin
      chk({tag, " dec conv"}, 32'(wc[0] - t_acc <= 21), 1);
      chk({tag, " ready time"}, t_rdy, wc[0] + 3);
    end
    chk({tag, " row"}, bus.cursor_row, mpos / 32);
    chk({tag, " col"}, bus.cursor_col, mpos % 32);
  endtask
  initial begin
    int n;
    logic [2:0] op;
    logic [15:0] d;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = 16'd0;
    bus.cmd_pal   = 1'b0;
    #12;
    chk("rst we", bus.vram_we, 0);
    chk("rst addr", bus.vram_addr, 0);
    chk("rst din", bus.vram_din, 0);
    chk("rst row", bus.cursor_row, 0);
    chk("rst col", bus.cursor_col, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst ready", bus.cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    start(3'd5, 16'h0305, 1'b0); finish("locate");
    start(3'd2, 16'h0041, 1'b1); finish("putc");
    chk("putc addr", got_a(0), 32'h065);
    chk("putc din", got_d(0), 32'hC1);
    chk("putc cursor", {27'd0, bus.cursor_row, bus.cursor_col} , {27'd0, 5'd3, 5'd6});
    start(3'd5, 16'h1F1E, 1'b0); finish("locate wrap");
    start(3'd4, 16'hBEEF, 1'b0); finish("hex16");
    chk("hex16 a2", got_a(2), 32'h000);
    chk("hex16 d3", got_d(3), 32'h46);
    chk("hex16 cursor", {27'd0, bus.cursor_row, bus.cursor_col}, {27'd0, 5'd0, 5'd2});
    start(3'd1, 16'h0000, 1'b1); finish("clear");
    start(3'd5, 16'h0A1C, 1'b0);
    t_prev = t_acc;
    start(3'd7, 16'h0000, 1'b1);
    chk("held valid accept", t_acc, t_prev + 2);
    finish("cleol");
    chk("cleol a0", got_a(0), 32'h15C);
    chk("cleol cursor", {27'd0, bus.cursor_row, bus.cursor_col}, {27'd0, 5'd10, 5'd28});
`ifdef JTFRAME_MSG_WRITER_DEC_EN
    start(3'd0, 16'd207, 1'b0); finish("dec8");
    chk("dec8 d0", got_d(0), 32'h32);
    chk("dec8 d1", got_d(1), 32'h30);
    chk("dec8 d2", got_d(2), 32'h37);
`else
    start(3'd0, 16'hFFFF, 1'b1); finish("nop");
`endif
    for (int k = 0; k < 60; k++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd1) op = 3'd7;
      d = 16'($urandom);
      start(op, d, 1'($urandom)); finish($sformatf("rnd%0d op%0d", k, op));
    end
    start(3'd1, 16'h0000, 1'b0);
    n = 0;
    while (wa.size() < 500 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mid clear we", bus.vram_we, 1);
    chk("mid clear addr", bus.vram_addr, 499);
    #1 rst = 1'b1;
    #1 chk("async rst we", bus.vram_we, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mpos = 0;
    repeat (10) @(negedge clk);
    chk("no writes after rst", wa.size(), 500);
    chk("post rst ready", bus.cmd_ready, 1);
    chk("post rst row", bus.cursor_row, 0);
    chk("post rst col", bus.cursor_col, 0);
    start(3'd2, 16'h005A, 1'b0); finish("putc after rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jtframe_msg_writer.md
Name: jtframe_msg_writer

Overview:
- Command-driven text engine that writes the credits/message VRAM (32 columns x 32 rows, 1024 bytes) through that VRAM's optional write port.
- A host issues cursor-relative character, hex-number, clear and positioning commands. The block does the addressing, digit conversion, fills and cursor wrap.
- It sits between a debug/CPU/ioctl source and the overlay's vram_addr/vram_din/vram_we inputs.

Parameters:
- BLANK, 8'h20: character code written by CLEAR and CLEOL fills (palette bit 0).
- ADDR_OFFSET, 10'd0: added to every generated VRAM address (mod 1024), used to target a page other than page 0.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  high when a command can be accepted
- cmd_op  in  3  opcode
- cmd_data  in  16  operand
- cmd_pal  in  1  palette bit; stored as VRAM data bit 7
- busy  out  1  high while a command is executing
- cursor_row  out  5  current row
- cursor_col  out  5  current column
- vram_addr  out  10  {row, col} + ADDR_OFFSET
- vram_din  out  8  {pal, char[6:0]}
- vram_we  out  1  write strobe, one byte per cycle

Behaviour:
- Reset (async): vram_we=0, vram_addr=0, vram_din=0, cursor 0/0, busy=0, cmd_ready=1, FSM=IDLE. Reset mid-command aborts the command at once; no further writes occur.
- Handshake: a command is accepted on a clk edge where cmd_valid && cmd_ready. cmd_op, cmd_data and cmd_pal are latched at that edge. cmd_ready=!busy. busy rises the cycle after acceptance and falls after the last write cycle. cmd_valid while busy is ignored.
- FSM states: IDLE, WRITE, FILL, DONE.
- All outputs are registered. A write is presented with vram_we=1 for exactly one cycle, with addr/din valid in that same cycle.
- Cursor advance after each character write:
  - col+1.
  - col 31 -> col 0, row+1.
  - row 31, col 31 -> row 0, col 0 (wrap, no scroll).
- Opcodes:
  - 0 NOP: no write. busy pulses for 1 cycle.
  - 1 CLEAR: writes {1'b0, BLANK[6:0]} to addresses 0..1023 in ascending order, 1024 consecutive we cycles. Then cursor=0/0. Addresses are offset by ADDR_OFFSET.
  - 2 PUTC: one write of {cmd_pal, cmd_data[6:0]} at the cursor; cursor advances.
  - 3 HEX8: 2 writes, most significant nibble first.
  - 4 HEX16: 4 writes, most significant nibble first.
  - Hex digit mapping: 0-9 -> 8'h30-8'h39; A-F -> 8'h41-8'h46. Palette bit = cmd_pal. Cursor advances per digit, wrapping mid-number if needed.
  - 5 LOCATE: row=cmd_data[12:8], col=cmd_data[4:0]. No write, 1 busy cycle.
  - 6 NEWLINE: col=0; row+1, with 31 wrapping to 0. No write.
  - 7 CLEOL: writes BLANK from the cursor column through column 31 of the current row, (32-col) writes. Cursor unchanged.
- Latency: the first vram_we occurs 1 cycle after acceptance. cmd_ready returns high the cycle after the last write.
- Back-to-back: total cost is N writes + 1 cycle. Example: PUTC accepted at edge t has its write in cycle t+1 and ready again at t+2.
- cursor_row/cursor_col update in the same cycle as the write that caused the advance is presented.

Optional Feature:
- Macro: JTFRAME_MSG_WRITER_DEC_EN.
- Defined: opcode 0 becomes DEC8.
  - Writes 3 zero-padded decimal digits (8'h30 + digit) of cmd_data[7:0], hundreds first.
  - Conversion is sequential by repeated subtraction of 100 then 10, so the FSM gains a CONV state.
  - Conversion takes at most 2+9+9 cycles before the first write. busy covers the conversion time.
- Undefined: opcode 0 is NOP as above; no CONV logic is synthesised.

Test Plan:
- Reset, then LOCATE 0x0305 followed by PUTC 0x41 pal=1 -> a single write addr=0x065, din=0xC1; cursor becomes 3/6.
- LOCATE row 31 col 30, then HEX16 0xBEEF pal=0 -> writes (0x3FE,0x42), (0x3FF,0x45), (0x000,0x45), (0x001,0x46); final cursor 0/2.
- CLEAR with ADDR_OFFSET=0 -> 1024 consecutive we cycles, addresses 0..1023, din=0x20 every cycle; cmd_ready=0 throughout; cursor 0/0 afterwards.
- LOCATE 0x0A1C, then CLEOL -> 4 writes at 0x15C..0x15F; cursor stays 10/28. A cmd_valid held during busy is not accepted until ready.
- Assert rst asynchronously during the 500th CLEAR write -> vram_we drops immediately; no writes after deassert; cmd_ready=1, cursor 0/0.
- With JTFRAME_MSG_WRITER_DEC_EN, DEC8 of 8'd207 -> writes 0x32, 0x30, 0x37 at consecutive addresses. Without the macro, opcode 0 -> no write and one busy cycle.
